// File: rtl/alu_operand_stage_if.sv
// Operand-B bus between decode/regfile (master) and the operand stage (slave).
// Beats move on valid & ready; a producer holds its beat stable until it sees ready.
interface alu_operand_stage_if #(
    parameter int WIDTH = 32,
    parameter int NSRC  = 3
);
    localparam int SELW = (NSRC > 1) ? $clog2(NSRC) : 1;

    logic [NSRC*WIDTH-1:0] src_data;
    logic [SELW-1:0]       sel;
    logic                  in_valid;
    logic                  in_ready;
    logic [WIDTH-1:0]      alu_in2;
    logic                  out_valid;
    logic                  out_ready;
    logic                  sel_err;
    logic [7:0]            err_cnt;
    logic                  err_clr;

    modport master (
        output src_data, sel, in_valid, out_ready, err_clr,
        input  in_ready, alu_in2, out_valid, sel_err, err_cnt
    );

    modport slave (
        input  src_data, sel, in_valid, out_ready, err_clr,
        output in_ready, alu_in2, out_valid, sel_err, err_cnt
    );
endinterface

// File: rtl/alu_operand_stage.sv
// ALU operand-B select with optional registered valid/ready stage and 2-entry skid buffer.
// Illegal selects deliver 0 with sel_err and bump a saturating error counter.
module alu_operand_stage #(
    parameter int WIDTH   = 32,
    parameter int NSRC    = 3,
    parameter int REG_OUT = 1
) (
    input  logic                clk,
    input  logic                rst_n,
    alu_operand_stage_if.slave  bus,
    output logic [1:0]          dbg_state_o
);
    localparam int SELW = (NSRC > 1) ? $clog2(NSRC) : 1;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_FULL  = 2'd2
    } state_e;

    logic [SELW-1:0]  sel;
    logic [WIDTH-1:0] sel_data;
    logic             illegal;
    logic             accept;
    logic [7:0]       err_cnt_q, err_cnt_d;

    assign sel     = bus.sel;
    assign illegal = ({1'b0, sel} >= (SELW+1)'(NSRC));
    assign accept  = bus.in_valid & bus.in_ready;

    // Out-of-range selects match no source and fall through to zero.
    always_comb begin
        sel_data = '0;
        for (int i = 0; i < NSRC; i++) begin
            if ({1'b0, sel} == (SELW+1)'(i)) begin
                sel_data = bus.src_data[i*WIDTH +: WIDTH];
            end
        end
    end

    always_comb begin
        err_cnt_d = err_cnt_q;
        if (bus.err_clr) begin
            err_cnt_d = '0;
        end else if (accept && illegal && (err_cnt_q != 8'hFF)) begin
            err_cnt_d = err_cnt_q + 8'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_cnt_q <= '0;
        end else begin
            err_cnt_q <= err_cnt_d;
        end
    end

    assign bus.err_cnt = err_cnt_q;

    generate
        if (REG_OUT != 0) begin : g_reg
            state_e           state_q, state_d;
            logic [WIDTH-1:0] main_data_q, main_data_d;
            logic [WIDTH-1:0] skid_data_q, skid_data_d;
            logic             main_err_q, main_err_d;
            logic             skid_err_q, skid_err_d;
            logic             deliver;

            assign deliver = bus.out_valid & bus.out_ready;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    state_q     <= ST_EMPTY;
                    main_data_q <= '0;
                    main_err_q  <= 1'b0;
                    skid_data_q <= '0;
                    skid_err_q  <= 1'b0;
                end else begin
                    state_q     <= state_d;
                    main_data_q <= main_data_d;
                    main_err_q  <= main_err_d;
                    skid_data_q <= skid_data_d;
                    skid_err_q  <= skid_err_d;
                end
            end

            always_comb begin
                state_d     = state_q;
                main_data_d = main_data_q;
                main_err_d  = main_err_q;
                skid_data_d = skid_data_q;
                skid_err_d  = skid_err_q;
                case (state_q)
                    ST_EMPTY: begin
                        if (accept) begin
                            main_data_d = sel_data;
                            main_err_d  = illegal;
                            state_d     = ST_ONE;
                        end
                    end
                    ST_ONE: begin
                        if (accept && deliver) begin
                            main_data_d = sel_data;
                            main_err_d  = illegal;
                        end else if (accept) begin
                            skid_data_d = sel_data;
                            skid_err_d  = illegal;
                            state_d     = ST_FULL;
                        end else if (deliver) begin
                            state_d = ST_EMPTY;
                        end
                    end
                    ST_FULL: begin
                        if (deliver) begin
                            main_data_d = skid_data_q;
                            main_err_d  = skid_err_q;
                            state_d     = ST_ONE;
                        end
                    end
                    default: state_d = ST_EMPTY;
                endcase
            end

            // in_ready decodes the state register only, so out_ready never reaches it.
            always_comb begin
                bus.out_valid = (state_q != ST_EMPTY);
                bus.in_ready  = (state_q != ST_FULL);
                bus.alu_in2   = main_data_q;
                bus.sel_err   = main_err_q;
                dbg_state_o   = state_q;
            end
        end else begin : g_comb
            assign bus.alu_in2   = sel_data;
            assign bus.sel_err   = illegal;
            assign bus.out_valid = bus.in_valid;
            assign bus.in_ready  = bus.out_ready;
            assign dbg_state_o   = 2'b00;
        end
    endgenerate
endmodule

// File: tb/tb_alu_operand_stage.sv
// Bench for alu_operand_stage: registered instance (tables, counter, reset, random) and
// combinational instance (passthrough behaviour).
module tb_alu_operand_stage;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic [1:0] dbg1, dbg0;

    always #5 clk = ~clk;

    alu_operand_stage_if #(.WIDTH(32), .NSRC(3)) b1 ();
    alu_operand_stage_if #(.WIDTH(32), .NSRC(3)) b0 ();

    alu_operand_stage #(.WIDTH(32), .NSRC(3), .REG_OUT(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .bus(b1), .dbg_state_o(dbg1)
    );
    alu_operand_stage #(.WIDTH(32), .NSRC(3), .REG_OUT(0)) dut0 (
        .clk(clk), .rst_n(rst_n), .bus(b0), .dbg_state_o(dbg0)
    );

    typedef struct {
        logic [1:0]  sel;
        logic        iv;
        logic        ordy;
        logic        clr;
        logic        e_valid;
        logic        e_ready;
        logic [31:0] e_data;
        logic        e_err;
        logic [7:0]  e_cnt;
    } vec_t;

    vec_t vecs[14];
    int n_cmp  = 0;
    int n_fail = 0;
    logic [32:0] exp_q[$];
    logic [95:0] fixed_src;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [32:0] model(input logic [95:0] src, input logic [1:0] s);
        logic [32:0] r;
        if (s < 2'd3) r = {1'b0, src[s*32 +: 32]};
        else          r = {1'b1, 32'd0};
        return r;
    endfunction

    task automatic pop_check();
        logic [32:0] e;
        if (exp_q.size() == 0) begin
            check("rand_unexpected_beat", 64'd1, 64'd0);
        end else begin
            e = exp_q.pop_front();
            check("rand_beat", {31'd0, b1.sel_err, b1.alu_in2}, {31'd0, e});
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int accepted;
        int cycles;
        int illegal_acc;
        logic pending;

        fixed_src = {32'h100, 32'd99, 32'd15};
        //            sel  iv  ordy clr  valid ready data      err  cnt
        vecs[0]  = '{2'd0, 1, 1, 0, 0, 1, 32'd0,     0, 8'd0};
        vecs[1]  = '{2'd1, 1, 1, 0, 1, 1, 32'd15,    0, 8'd0};
        vecs[2]  = '{2'd0, 0, 1, 0, 1, 1, 32'd99,    0, 8'd0};
        vecs[3]  = '{2'd0, 0, 1, 0, 0, 1, 32'd0,     0, 8'd0};
        vecs[4]  = '{2'd0, 1, 0, 0, 0, 1, 32'd0,     0, 8'd0};
        vecs[5]  = '{2'd1, 1, 0, 0, 1, 1, 32'd15,    0, 8'd0};
        vecs[6]  = '{2'd2, 1, 0, 0, 1, 0, 32'd15,    0, 8'd0};
        vecs[7]  = '{2'd0, 0, 1, 0, 1, 0, 32'd15,    0, 8'd0};
        vecs[8]  = '{2'd2, 1, 1, 0, 1, 1, 32'd99,    0, 8'd0};
        vecs[9]  = '{2'd0, 0, 1, 0, 1, 1, 32'h100,   0, 8'd0};
        vecs[10] = '{2'd0, 0, 0, 0, 0, 1, 32'd0,     0, 8'd0};
        vecs[11] = '{2'd3, 1, 1, 0, 0, 1, 32'd0,     0, 8'd0};
        vecs[12] = '{2'd0, 0, 1, 0, 1, 1, 32'd0,     1, 8'd1};
        vecs[13] = '{2'd0, 0, 1, 0, 0, 1, 32'd0,     0, 8'd1};

        b1.src_data = fixed_src; b1.sel = '0; b1.in_valid = 0; b1.out_ready = 0; b1.err_clr = 0;
        b0.src_data = fixed_src; b0.sel = '0; b0.in_valid = 0; b0.out_ready = 0; b0.err_clr = 0;

        // Reset state
        repeat (2) @(negedge clk);
        check("rst_out_valid", {63'd0, b1.out_valid}, 64'd0);
        check("rst_in_ready",  {63'd0, b1.in_ready}, 64'd1);
        check("rst_alu_in2",   {32'd0, b1.alu_in2}, 64'd0);
        check("rst_sel_err",   {63'd0, b1.sel_err}, 64'd0);
        check("rst_err_cnt",   {56'd0, b1.err_cnt}, 64'd0);
        check("rst_state",     {62'd0, dbg1}, 64'd0);
        rst_n = 1'b1;

        // Ordered transfers, back-pressure and a first illegal beat
        for (int i = 0; i < 14; i++) begin
            @(negedge clk);
            b1.sel = vecs[i].sel; b1.in_valid = vecs[i].iv;
            b1.out_ready = vecs[i].ordy; b1.err_clr = vecs[i].clr;
            #1;
            check($sformatf("vec%0d_out_valid", i), {63'd0, b1.out_valid}, {63'd0, vecs[i].e_valid});
            check($sformatf("vec%0d_in_ready", i),  {63'd0, b1.in_ready},  {63'd0, vecs[i].e_ready});
            check($sformatf("vec%0d_err_cnt", i),   {56'd0, b1.err_cnt},   {56'd0, vecs[i].e_cnt});
            if (vecs[i].e_valid) begin
                check($sformatf("vec%0d_alu_in2", i), {32'd0, b1.alu_in2}, {32'd0, vecs[i].e_data});
                check($sformatf("vec%0d_sel_err", i), {63'd0, b1.sel_err}, {63'd0, vecs[i].e_err});
            end
        end

        // Saturation: 300 more illegal beats on top of the one already counted
        for (int k = 0; k < 300; k++) begin
            @(negedge clk);
            b1.sel = 2'd3; b1.in_valid = 1; b1.out_ready = 1;
            #1;
            if (k == 253) check("cnt_254", {56'd0, b1.err_cnt}, 64'd254);
        end
        @(negedge clk);
        b1.in_valid = 0;
        #1 check("cnt_sat_255", {56'd0, b1.err_cnt}, 64'd255);

        // Clear wins over a simultaneous illegal beat
        @(negedge clk);
        b1.sel = 2'd3; b1.in_valid = 1; b1.err_clr = 1;
        @(negedge clk);
        b1.in_valid = 0; b1.err_clr = 0;
        #1 check("cnt_clr_priority", {56'd0, b1.err_cnt}, 64'd0);
        @(negedge clk);
        b1.in_valid = 1;
        @(negedge clk);
        b1.in_valid = 0;
        #1 check("cnt_after_clr", {56'd0, b1.err_cnt}, 64'd1);

        // Async reset while FULL
        repeat (2) @(negedge clk);
        b1.out_ready = 0; b1.in_valid = 1; b1.sel = 2'd3;
        @(negedge clk);
        b1.sel = 2'd0;
        @(negedge clk);
        b1.in_valid = 0;
        #1;
        check("full_in_ready",  {63'd0, b1.in_ready}, 64'd0);
        check("full_out_valid", {63'd0, b1.out_valid}, 64'd1);
        check("full_err_cnt",   {56'd0, b1.err_cnt}, 64'd2);
        #1 rst_n = 1'b0;
        #1;
        check("arst_out_valid", {63'd0, b1.out_valid}, 64'd0);
        check("arst_in_ready",  {63'd0, b1.in_ready}, 64'd1);
        check("arst_alu_in2",   {32'd0, b1.alu_in2}, 64'd0);
        check("arst_sel_err",   {63'd0, b1.sel_err}, 64'd0);
        check("arst_err_cnt",   {56'd0, b1.err_cnt}, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Combinational instance: outputs follow inputs between clock edges
        @(negedge clk);
        b0.in_valid = 1; b0.out_ready = 0; b0.sel = 2'd0;
        #1;
        check("comb_sel0",      {32'd0, b0.alu_in2}, 64'd15);
        check("comb_out_valid", {63'd0, b0.out_valid}, 64'd1);
        check("comb_in_ready0", {63'd0, b0.in_ready}, 64'd0);
        b0.sel = 2'd1;
        #1 check("comb_sel1", {32'd0, b0.alu_in2}, 64'd99);
        b0.sel = 2'd3; b0.out_ready = 1;
        #1;
        check("comb_illegal_data", {32'd0, b0.alu_in2}, 64'd0);
        check("comb_illegal_err",  {63'd0, b0.sel_err}, 64'd1);
        check("comb_in_ready1",    {63'd0, b0.in_ready}, 64'd1);
        @(negedge clk);
        check("comb_err_cnt", {56'd0, b0.err_cnt}, 64'd1);
        b0.in_valid = 0;
        #1 check("comb_out_valid0", {63'd0, b0.out_valid}, 64'd0);

        // Random valid/ready traffic against the scoreboard
        accepted = 0; cycles = 0; illegal_acc = 0; pending = 0;
        while (accepted < 1000 && cycles < 20000) begin
            @(negedge clk);
            cycles++;
            if (!pending && $urandom_range(0, 3) != 0) begin
                pending = 1;
                b1.sel = 2'($urandom_range(0, 3));
                b1.src_data = {$urandom, $urandom, $urandom};
            end
            b1.in_valid  = pending;
            b1.out_ready = ($urandom_range(0, 2) != 0);
            #1;
            if (b1.out_valid && b1.out_ready) pop_check();
            if (b1.in_valid && b1.in_ready) begin
                exp_q.push_back(model(b1.src_data, b1.sel));
                if (b1.sel == 2'd3) illegal_acc++;
                accepted++;
                pending = 0;
            end
        end
        if (accepted < 1000) check("rand_cycle_budget", 64'(accepted), 64'd1000);
        @(negedge clk);
        b1.in_valid = 0; b1.out_ready = 1;
        for (int c = 0; c < 10 && exp_q.size() > 0; c++) begin
            #1;
            if (b1.out_valid) pop_check();
            @(negedge clk);
        end
        #1;
        check("rand_queue_drained", 64'(exp_q.size()), 64'd0);
        check("rand_out_valid_idle", {63'd0, b1.out_valid}, 64'd0);
        check("rand_err_cnt", {56'd0, b1.err_cnt}, (illegal_acc > 255) ? 64'd255 : 64'(illegal_acc));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
